fpga_cfg_loader: RTL and testbench



---
 rtl/fpga_cfg_pkg.sv | 19 +
 rtl/cfg_crc8.sv | 19 +
 rtl/fpga_cfg_loader.sv | 142 ++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared types and defaults for the configuration bitstream loader.
package fpga_cfg_pkg;

  localparam int unsigned LEN_W = 16;

  localparam logic [7:0] MAGIC_DEFAULT    = 8'hA5;
  localparam logic [7:0] CRC_POLY_DEFAULT = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    LOAD,
    SHIFT,
    CRC,
    LATCH
  } state_t;

endpackage

// File: rtl/cfg_crc8.sv
// Combinational CRC-8 step: MSB-first, no reflection, one byte per call.
module cfg_crc8 (
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  input  logic [7:0] poly,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ byte_in;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ poly) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Framed byte-stream receiver that CRC-checks and bit-serially shifts the
// payload into the fabric configuration chain, pulsing a commit on success.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter logic [7:0] MAGIC    = MAGIC_DEFAULT,
  parameter logic [7:0] CRC_POLY = CRC_POLY_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cfg_data,
  output logic       cfg_en,
  output logic       cfg_latch,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t             state, state_n;
  logic [LEN_W-1:0]   rem, rem_n;
  logic [2:0]         bit_cnt, bit_cnt_n;
  logic [7:0]         shreg, shreg_n;
  logic [7:0]         crc, crc_n, crc_calc;
  logic               done_n, err_n;
  logic               xfer;
  logic               ready_n, en_n, data_n, latch_n, busy_n;

  cfg_crc8 u_crc (
    .crc_in  (crc),
    .byte_in (in_data),
    .poly    (CRC_POLY),
    .crc_out (crc_calc)
  );

  assign xfer = in_valid && in_ready;

  always_comb begin
    state_n   = state;
    rem_n     = rem;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    crc_n     = crc;
    done_n    = done;
    err_n     = err;

    case (state)
      IDLE: begin
        if (xfer && in_data == MAGIC) begin
          state_n = LEN_HI;
          done_n  = 1'b0;
          err_n   = 1'b0;
          crc_n   = '0;
          rem_n   = '0;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          rem_n[15:8] = in_data;
          state_n     = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          rem_n[7:0] = in_data;
          state_n    = ({rem[15:8], in_data} != '0) ? LOAD : CRC;
        end
      end
      LOAD: begin
        if (xfer) begin
          shreg_n   = in_data;
          crc_n     = crc_calc;
          rem_n     = rem - 16'd1;
          bit_cnt_n = '0;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        shreg_n   = shreg >> 1;
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          state_n = (rem != '0) ? LOAD : CRC;
        end
      end
      CRC: begin
        if (xfer) begin
          if (in_data == crc) begin
            state_n = LATCH;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      LATCH: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ready_n = (state_n inside {IDLE, LEN_HI, LEN_LO, LOAD, CRC});
    en_n    = (state_n == SHIFT);
    data_n  = en_n & shreg_n[0];
    latch_n = (state_n == LATCH);
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      crc       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      cfg_en    <= 1'b0;
      cfg_data  <= 1'b0;
      cfg_latch <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      crc       <= crc_n;
      done      <= done_n;
      err       <= err_n;
      in_ready  <= ready_n;
      cfg_en    <= en_n;
      cfg_data  <= data_n;
      cfg_latch <= latch_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader with hand-computed frames and CRCs.
module tb_fpga_cfg_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       cfg_data;
  logic       cfg_en;
  logic       cfg_latch;
  logic       busy;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic bits[$];
  int   latch_cnt   = 0;
  int   overlap_cnt = 0;
  int   stray_cnt   = 0;

  fpga_cfg_loader #(.MAGIC(8'hA5), .CRC_POLY(8'h07)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg_data  (cfg_data),
    .cfg_en    (cfg_en),
    .cfg_latch (cfg_latch),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_en) bits.push_back(cfg_data);
    else if (cfg_data) stray_cnt++;
    if (cfg_latch) latch_cnt++;
    if (cfg_en && in_ready) overlap_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout byte=%h got in_ready=%b want 1", b, in_ready);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk); @(negedge clk);
    total++;
    if ({in_ready, cfg_data, cfg_en, cfg_latch, busy, done, err} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_state got=%b want=1000000",
               {in_ready, cfg_data, cfg_en, cfg_latch, busy, done, err});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int b0, l0;
    logic [7:0] got;
    b0 = bits.size(); l0 = latch_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h07);
    total++;
    if (cfg_latch !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL single_latch got latch=%b done=%b want latch=1 done=0", cfg_latch, done);
    end
    @(negedge clk);
    total++;
    if ({cfg_latch, done, err, in_ready, busy} !== 5'b01010) begin
      bad++;
      $display("FAIL single_after got=%b want=01010", {cfg_latch, done, err, in_ready, busy});
    end
    total++;
    if (bits.size() - b0 !== 8) begin
      bad++;
      $display("FAIL single_bitcount got=%0d want=8", bits.size() - b0);
    end else begin
      for (int i = 0; i < 8; i++) got[i] = bits[b0 + i];
      total++;
      if (got !== 8'h01) begin
        bad++;
        $display("FAIL single_data got=%h want=01", got);
      end
    end
    total++;
    if (latch_cnt - l0 !== 1) begin
      bad++;
      $display("FAIL single_latchcount got=%0d want=1", latch_cnt - l0);
    end
  endtask

  task automatic test_two_byte();
    int b0, o0, errs;
    logic [15:0] got;
    b0 = bits.size(); o0 = overlap_cnt; errs = 0;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01);
    for (int i = 0; i < 8; i++) begin
      if (in_ready !== 1'b0 || cfg_en !== 1'b1) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL two_shift_window got bad_cycles=%0d want=0", errs);
    end
    total++;
    if (in_ready !== 1'b1 || cfg_en !== 1'b0) begin
      bad++;
      $display("FAIL two_ready_k9 got ready=%b en=%b want ready=1 en=0", in_ready, cfg_en);
    end
    send_byte(8'h02); send_byte(8'h1B);
    total++;
    if (cfg_latch !== 1'b1) begin
      bad++;
      $display("FAIL two_latch got=%b want=1", cfg_latch);
    end
    @(negedge clk);
    total++;
    if ({done, err} !== 2'b10) begin
      bad++;
      $display("FAIL two_status got done,err=%b want=10", {done, err});
    end
    total++;
    if (bits.size() - b0 !== 16) begin
      bad++;
      $display("FAIL two_bitcount got=%0d want=16", bits.size() - b0);
    end else begin
      for (int i = 0; i < 16; i++) got[i] = bits[b0 + i];
      total++;
      if (got !== 16'h0201) begin
        bad++;
        $display("FAIL two_data got=%h want=0201", got);
      end
    end
    total++;
    if (overlap_cnt - o0 !== 0) begin
      bad++;
      $display("FAIL two_ready_during_shift got=%0d want=0", overlap_cnt - o0);
    end
  endtask

  task automatic test_bad_crc();
    int b0, l0;
    b0 = bits.size(); l0 = latch_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h08);
    total++;
    if ({err, done, in_ready, cfg_latch, busy} !== 5'b10100) begin
      bad++;
      $display("FAIL bad_status got err,done,rdy,latch,busy=%b want=10100",
               {err, done, in_ready, cfg_latch, busy});
    end
    @(negedge clk);
    total++;
    if (latch_cnt - l0 !== 0 || bits.size() - b0 !== 8) begin
      bad++;
      $display("FAIL bad_counts got latches=%0d bits=%0d want 0 and 8",
               latch_cnt - l0, bits.size() - b0);
    end
    send_byte(8'hA5);
    total++;
    if ({err, done, busy} !== 3'b001) begin
      bad++;
      $display("FAIL magic_clears got err,done,busy=%b want=001", {err, done, busy});
    end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h01); send_byte(8'h07);
    total++;
    if (cfg_latch !== 1'b1) begin
      bad++;
      $display("FAIL recover_latch got=%b want=1", cfg_latch);
    end
    @(negedge clk);
    total++;
    if ({done, err} !== 2'b10) begin
      bad++;
      $display("FAIL recover_status got done,err=%b want=10", {done, err});
    end
  endtask

  task automatic test_zero_len();
    int b0;
    b0 = bits.size();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    total++;
    if (cfg_latch !== 1'b1) begin
      bad++;
      $display("FAIL zero_latch got=%b want=1", cfg_latch);
    end
    @(negedge clk);
    total++;
    if ({done, err} !== 2'b10 || bits.size() - b0 !== 0) begin
      bad++;
      $display("FAIL zero_status got done,err=%b bits=%0d want 10 and 0",
               {done, err}, bits.size() - b0);
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    total++;
    if ({err, done, cfg_latch, in_ready} !== 4'b1001) begin
      bad++;
      $display("FAIL zero_badcrc got err,done,latch,rdy=%b want=1001",
               {err, done, cfg_latch, in_ready});
    end
    @(negedge clk);
  endtask

  task automatic test_garbage();
    int b0, l0;
    logic [7:0] got;
    l0 = latch_cnt;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    total++;
    if ({busy, done, err, in_ready} !== 4'b0011 || latch_cnt - l0 !== 0) begin
      bad++;
      $display("FAIL garbage_ignored got busy,done,err,rdy=%b latches=%0d want 0011 and 0",
               {busy, done, err, in_ready}, latch_cnt - l0);
    end
    b0 = bits.size();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hA5); send_byte(8'h72);
    total++;
    if (cfg_latch !== 1'b1) begin
      bad++;
      $display("FAIL garbage_latch got=%b want=1", cfg_latch);
    end
    @(negedge clk);
    total++;
    if ({done, err} !== 2'b10) begin
      bad++;
      $display("FAIL garbage_status got done,err=%b want=10", {done, err});
    end
    total++;
    if (bits.size() - b0 !== 8) begin
      bad++;
      $display("FAIL garbage_bitcount got=%0d want=8", bits.size() - b0);
    end else begin
      for (int i = 0; i < 8; i++) got[i] = bits[b0 + i];
      total++;
      if (got !== 8'hA5) begin
        bad++;
        $display("FAIL magic_as_data got=%h want=a5", got);
      end
    end
  endtask

  task automatic test_reset_mid();
    int l0;
    l0 = latch_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'hF0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    total++;
    if (cfg_en !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre got cfg_en=%b want=1", cfg_en);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, cfg_data, cfg_en, cfg_latch, busy, done, err} !== 7'b1000000) begin
      bad++;
      $display("FAIL midreset_state got=%b want=1000000",
               {in_ready, cfg_data, cfg_en, cfg_latch, busy, done, err});
    end
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if (latch_cnt - l0 !== 0) begin
      bad++;
      $display("FAIL midreset_nolatch got=%0d want=0", latch_cnt - l0);
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h01); send_byte(8'h07);
    total++;
    if (cfg_latch !== 1'b1) begin
      bad++;
      $display("FAIL midreset_follow_latch got=%b want=1", cfg_latch);
    end
    @(negedge clk);
    total++;
    if ({done, err, busy} !== 3'b100) begin
      bad++;
      $display("FAIL midreset_follow_status got done,err,busy=%b want=100", {done, err, busy});
    end
  endtask

  task automatic test_idle_data();
    total++;
    if (stray_cnt !== 0) begin
      bad++;
      $display("FAIL data_without_en got=%0d want=0", stray_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_two_byte();
    test_bad_crc();
    test_zero_len();
    test_garbage();
    test_reset_mid();
    test_idle_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
